// File: rtl/mips_pkg.sv
// mips_pkg: shared PCSrc encodings, instruction field bit positions and opcodes
package mips_pkg;
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;
  localparam logic [1:0] PCSRC_HOLD = 2'b11;
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
endpackage

// File: rtl/mips_trace_buf.sv
// mips_trace_buf: circular buffer of taken-transfer PCs, newest-relative read
module mips_trace_buf #(
  parameter int TRACE_DEPTH = 8,
  localparam int IW = $clog2(TRACE_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [31:0]   push_pc,
  input  logic [IW-1:0] idx,
  output logic [31:0]   rd_pc,
  output logic [IW:0]   count
);
  logic [31:0] mem_q [TRACE_DEPTH];
  logic [31:0] mem_d [TRACE_DEPTH];
  logic [IW-1:0] head_q, head_d;
  logic [IW:0] count_q, count_d;
  // write at head, advance head, count saturates at depth
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[head_q] = push_pc;
    head_d = push ? head_q + IW'(1) : head_q;
    count_d = (push && count_q != (IW+1)'(TRACE_DEPTH)) ? count_q + (IW+1)'(1) : count_q;
  end
  // buffer state, emptied on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      head_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      head_q <= head_d;
      count_q <= count_d;
    end
  end
  assign rd_pc = ({1'b0, idx} < count_q) ? mem_q[head_q - IW'(1) - idx] : '0;
  assign count = count_q;
endmodule

// File: rtl/mips_pc_ir.sv
// mips_pc_ir: PC/IR/MDR/ALUOut stage with retire counter, sticky flags, optional trace (MIPS_PC_TRACE_EN)
module mips_pc_ir
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 32,
  parameter int TRACE_DEPTH = 8,
  localparam int IW = $clog2(TRACE_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             Branch_Cntrl,
  input  logic             IRWrite,
  input  logic             IorD,
  input  logic [1:0]       PCSrc,
  input  logic             zero,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      instr,
  output logic [31:0]      mdr,
  output logic [31:0]      alu_out,
  output logic [5:0]       OpCode,
  output logic [5:0]       Function,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [15:0]      imm,
  output logic [CNT_W-1:0] retired,
  output logic             misalign,
  output logic             halted,
  input  logic [IW-1:0]    trace_idx,
  output logic [31:0]      trace_pc,
  output logic [IW:0]      trace_count
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d, mdr_q, mdr_d, alu_out_q, alu_out_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic misalign_q, misalign_d, halted_q, halted_d;
  logic pc_en, push;
  logic [31:0] next_pc;
  // next-state for PC, IR, data registers, counter and sticky flags
  always_comb begin
    pc_en = PCWrite | (Branch_Cntrl & zero);
    next_pc = PCSrc == PCSRC_SEQ ? alu_result :
              PCSrc == PCSRC_BR  ? alu_out_q :
              PCSrc == PCSRC_JMP ? {pc_q[31:28], instr_q[TGT_HI:TGT_LO], 2'b00} : pc_q;
    push = pc_en & (PCSrc == PCSRC_BR || PCSrc == PCSRC_JMP);
    pc_d = pc_en ? {next_pc[31:2], 2'b00} : pc_q;
    misalign_d = misalign_q | (pc_en & (|next_pc[1:0]));
    halted_d = halted_q | (pc_en & PCSrc == PCSRC_JMP & next_pc == pc_q);
    instr_d = IRWrite ? mem_rdata : instr_q;
    retired_d = (IRWrite && !(&retired_q)) ? retired_q + CNT_W'(1) : retired_q;
    mdr_d = mem_rdata;
    alu_out_d = alu_result;
  end
  // architectural state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      instr_q <= '0;
      mdr_q <= '0;
      alu_out_q <= '0;
      retired_q <= '0;
      misalign_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      mdr_q <= mdr_d;
      alu_out_q <= alu_out_d;
      retired_q <= retired_d;
      misalign_q <= misalign_d;
      halted_q <= halted_d;
    end
  end
  assign mem_addr = IorD ? alu_out_q : pc_q;
  assign pc = pc_q;
  assign instr = instr_q;
  assign mdr = mdr_q;
  assign alu_out = alu_out_q;
  assign OpCode = instr_q[OP_HI:OP_LO];
  assign Function = instr_q[FN_HI:FN_LO];
  assign rs = instr_q[RS_HI:RS_LO];
  assign rt = instr_q[RT_HI:RT_LO];
  assign rd = instr_q[RD_HI:RD_LO];
  assign shamt = instr_q[SH_HI:SH_LO];
  assign imm = instr_q[IMM_HI:IMM_LO];
  assign retired = retired_q;
  assign misalign = misalign_q;
  assign halted = halted_q;
`ifdef MIPS_PC_TRACE_EN
  mips_trace_buf #(.TRACE_DEPTH(TRACE_DEPTH)) u_trace (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_pc(pc_q),
    .idx(trace_idx),
    .rd_pc(trace_pc),
    .count(trace_count)
  );
`else
  logic unused_trace;
  assign unused_trace = ^{push, trace_idx};
  assign trace_pc = '0;
  assign trace_count = '0;
`endif
endmodule

// File: tb/tb_mips_pc_ir.sv
// tb_mips_pc_ir: scoreboard bench for mips_pc_ir against a small behavioural model
module tb_mips_pc_ir;
  localparam int D = 8;
  logic clk = 0, rst = 0;
  logic PCWrite = 0, Branch_Cntrl = 0, IRWrite = 0, IorD = 0, zero = 0;
  logic [1:0] PCSrc = 0;
  logic [31:0] alu_result = 0, mem_rdata = 0;
  logic [2:0] trace_idx = 0;
  logic [31:0] mem_addr, pc, instr, mdr, alu_out, trace_pc;
  logic [5:0] OpCode, Function;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [3:0] retired, trace_count;
  logic misalign, halted;
  int vectors = 0, miscompares = 0;

  typedef struct packed {
    logic [31:0] pc, instr, mdr, alu_out, mem_addr;
    logic [3:0] retired;
    logic misalign, halted;
    logic [3:0] tcount;
    logic [31:0] tpc;
    logic [5:0] op, fn;
    logic [4:0] rs;
    logic [15:0] imm;
  } snap_t;

  logic [31:0] m_pc, m_instr, m_mdr, m_alu;
  logic [3:0] m_ret;
  logic m_mis, m_halt;
  logic [31:0] tq[$];
  snap_t sb[$];
  snap_t e, o;

  mips_pc_ir #(.RESET_PC(32'h0), .CNT_W(4), .TRACE_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .Branch_Cntrl(Branch_Cntrl),
    .IRWrite(IRWrite), .IorD(IorD), .PCSrc(PCSrc), .zero(zero),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .pc(pc), .instr(instr), .mdr(mdr), .alu_out(alu_out), .OpCode(OpCode),
    .Function(Function), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .retired(retired), .misalign(misalign), .halted(halted),
    .trace_idx(trace_idx), .trace_pc(trace_pc), .trace_count(trace_count)
  );

  always #5 clk = ~clk;

  function automatic snap_t expect_now();
    snap_t s;
    s.pc = m_pc; s.instr = m_instr; s.mdr = m_mdr; s.alu_out = m_alu;
    s.mem_addr = IorD ? m_alu : m_pc;
    s.retired = m_ret; s.misalign = m_mis; s.halted = m_halt;
`ifdef MIPS_PC_TRACE_EN
    s.tcount = 4'(tq.size());
    s.tpc = (int'(trace_idx) < tq.size()) ? tq[trace_idx] : 32'h0;
`else
    s.tcount = 4'h0;
    s.tpc = 32'h0;
`endif
    s.op = m_instr[31:26]; s.fn = m_instr[5:0]; s.rs = m_instr[25:21]; s.imm = m_instr[15:0];
    return s;
  endfunction

  function automatic snap_t observed();
    snap_t s;
    s.pc = pc; s.instr = instr; s.mdr = mdr; s.alu_out = alu_out; s.mem_addr = mem_addr;
    s.retired = retired; s.misalign = misalign; s.halted = halted;
    s.tcount = trace_count; s.tpc = trace_pc;
    s.op = OpCode; s.fn = Function; s.rs = rs; s.imm = imm;
    return s;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_mdr = 0; m_alu = 0; m_ret = 0; m_mis = 0; m_halt = 0;
    tq.delete();
  endtask

  task automatic drive(input logic pw, bc, z, irw, iord, input logic [1:0] src,
                       input logic [31:0] ar, md);
    logic en;
    logic [31:0] np;
    PCWrite = pw; Branch_Cntrl = bc; zero = z; IRWrite = irw; IorD = iord;
    PCSrc = src; alu_result = ar; mem_rdata = md;
    en = pw | (bc & z);
    np = src == 2'b00 ? ar : src == 2'b01 ? m_alu :
         src == 2'b10 ? {m_pc[31:28], m_instr[25:0], 2'b00} : m_pc;
    if (en && np[1:0] != 2'b00) m_mis = 1;
    if (en && src == 2'b10 && np == m_pc) m_halt = 1;
    if (en && (src == 2'b01 || src == 2'b10)) begin
      tq.push_front(m_pc);
      if (tq.size() > D) void'(tq.pop_back());
    end
    if (en) m_pc = {np[31:2], 2'b00};
    if (irw) begin
      m_instr = md;
      if (m_ret != 4'hf) m_ret = m_ret + 4'h1;
    end
    m_mdr = md; m_alu = ar;
    sb.push_back(expect_now());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0;
    #1;
    model_reset();
    sb.push_back(expect_now());
    e = sb.pop_front(); o = observed(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL reset got=%h exp=%h", o, e); end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_fetch();
    drive(1, 0, 0, 1, 0, 2'b00, 32'h4, 32'h0000_0020);
    e = sb.pop_front(); o = observed(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL fetch got=%h exp=%h", o, e); end
    vectors++;
    if (Function !== 6'h20 || retired !== 4'h1 || pc !== 32'h4) begin
      miscompares++;
      $display("FAIL fetch_fields got fn=%h ret=%h pc=%h exp fn=20 ret=1 pc=4", Function, retired, pc);
    end
  endtask

  task automatic test_branch();
    drive(1, 0, 0, 0, 0, 2'b00, 32'h8, 32'h0);
    e = sb.pop_front(); o = observed(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL br_setpc got=%h exp=%h", o, e); end
    drive(0, 0, 0, 0, 0, 2'b00, 32'h40, 32'h0);
    e = sb.pop_front(); o = observed(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL br_target got=%h exp=%h", o, e); end
    drive(0, 1, 0, 0, 0, 2'b01, 32'h40, 32'h0);
    e = sb.pop_front(); o = observed(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL br_not_taken got=%h exp=%h", o, e); end
    drive(0, 1, 1, 0, 0, 2'b01, 32'h40, 32'h0);
    e = sb.pop_front(); o = observed(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL br_taken got=%h exp=%h", o, e); end
  endtask

  task automatic test_jump_halt();
    drive(1, 0, 0, 1, 0, 2'b00, 32'h1000_0010, 32'h0800_0004);
    e = sb.pop_front(); o = observed(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL jmp_setup got=%h exp=%h", o, e); end
    drive(1, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0);
    e = sb.pop_front(); o = observed(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL jmp_self got=%h exp=%h", o, e); end
    vectors++;
    if (halted !== 1'b1 || pc !== 32'h1000_0010) begin
      miscompares++;
      $display("FAIL halted got h=%b pc=%h exp h=1 pc=10000010", halted, pc);
    end
    #2;
    test_reset();
  endtask

  task automatic test_misalign();
    drive(1, 0, 0, 0, 0, 2'b00, 32'h6, 32'h0);
    e = sb.pop_front(); o = observed(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL misalign_set got=%h exp=%h", o, e); end
    drive(1, 0, 0, 0, 0, 2'b00, 32'h8, 32'h0);
    e = sb.pop_front(); o = observed(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL misalign_sticky got=%h exp=%h", o, e); end
  endtask

  task automatic test_trace();
    test_reset();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 1, 0, 2'b00, 32'h0, 32'(k + 1));
      e = sb.pop_front(); o = observed(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL trace_ld%0d got=%h exp=%h", k, o, e); end
      drive(1, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0);
      e = sb.pop_front(); o = observed(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL trace_jmp%0d got=%h exp=%h", k, o, e); end
    end
    for (int i = 0; i < D; i += 7) begin
      trace_idx = 3'(i);
      #1;
      sb.push_back(expect_now());
      e = sb.pop_front(); o = observed(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL trace_idx%0d got=%h exp=%h", i, o, e); end
    end
    trace_idx = 0;
  endtask

  task automatic test_retired_sat();
    for (int n = 0; n < 20 && m_ret != 4'he; n++) begin
      drive(0, 0, 0, 1, 0, 2'b11, 32'h0, 32'h0);
      e = sb.pop_front(); o = observed(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL ret_ramp got=%h exp=%h", o, e); end
    end
    for (int n = 0; n < 2; n++) begin
      drive(0, 0, 0, 1, 0, 2'b11, 32'h0, 32'h0);
      e = sb.pop_front(); o = observed(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL ret_sat got=%h exp=%h", o, e); end
    end
    vectors++;
    if (retired !== 4'hf) begin miscompares++; $display("FAIL ret_allones got=%h exp=f", retired); end
  endtask

  task automatic test_mem_addr();
    drive(1, 0, 0, 0, 0, 2'b11, 32'h80, 32'h0);
    e = sb.pop_front(); o = observed(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL hold got=%h exp=%h", o, e); end
    drive(0, 0, 0, 0, 1, 2'b00, 32'h80, 32'h0);
    e = sb.pop_front(); o = observed(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL iord got=%h exp=%h", o, e); end
    vectors++;
    if (mem_addr !== 32'h80) begin miscompares++; $display("FAIL mem_addr got=%h exp=00000080", mem_addr); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_branch();
    test_jump_halt();
    test_misalign();
    test_trace();
    test_retired_sat();
    test_mem_addr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
